nbody_host_seq: RTL and testbench

- Avalon-style bus initiator that drives the nbody accelerator register/memory map in place of software.
- Accepts a stream of initial body states and loads them into the accelerator.
- Programs N_BODIES and GAP, raises GO, polls DONE, and performs the READ handshake.
- Streams the final x/y positions out; optionally re-triggers further frames without reloading.

---
 rtl/nbody_host_seq.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_nbody_host_seq.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nbody_host_seq.sv
// Bus initiator that drives the nbody accelerator in place of software: configure,
// load bodies, run, poll DONE, stream positions back, and optionally keep re-running.
module nbody_host_seq #(
    parameter int BODIES        = 512,
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 16,
    parameter int ReadLatency   = 2,
    parameter int PollInterval  = 16,
    parameter int TimeoutCycles = 2**24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(BODIES)-1:0]  n_bodies,
    input  logic [DATA_WIDTH-1:0]      gap,
    input  logic                       continuous,
    input  logic                       stop,
    input  logic                       body_valid,
    output logic                       body_ready,
    input  logic [DATA_WIDTH-1:0]      body_x,
    input  logic [DATA_WIDTH-1:0]      body_y,
    input  logic [DATA_WIDTH-1:0]      body_m,
    input  logic [DATA_WIDTH-1:0]      body_vx,
    input  logic [DATA_WIDTH-1:0]      body_vy,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(BODIES)-1:0]  res_idx,
    output logic [DATA_WIDTH-1:0]      res_x,
    output logic [DATA_WIDTH-1:0]      res_y,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       error,
    output logic [ADDR_WIDTH-1:0]      address,
    output logic [DATA_WIDTH-1:0]      writedata,
    output logic                       read,
    output logic                       write,
    output logic                       chipselect,
    input  logic [DATA_WIDTH-1:0]      readdata
);

    localparam int BAW = $clog2(BODIES);
    localparam int OPW = ADDR_WIDTH - BAW;
    localparam int TW  = $clog2(TimeoutCycles + 1);
    localparam int RCW = $clog2(ReadLatency + 1);
    localparam int PW  = $clog2(PollInterval + 1);

    localparam logic [OPW-1:0] OP_GO     = OPW'(8'h00);
    localparam logic [OPW-1:0] OP_READ   = OPW'(8'h01);
    localparam logic [OPW-1:0] OP_NBODY  = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_X      = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_GAP    = OPW'(8'h08);
    localparam logic [OPW-1:0] OP_DONE   = OPW'(8'h40);
    localparam logic [OPW-1:0] OP_RX     = OPW'(8'h41);
    localparam logic [OPW-1:0] OP_RY     = OPW'(8'h42);
    localparam logic [BAW-1:0] IDX0      = '0;

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_LOAD, S_ARM, S_POLL, S_RDBK, S_END
    } state_t;

    state_t                state_q;
    logic [2:0]            step_q;
    logic [BAW-1:0]        idx_q;
    logic [BAW-1:0]        n_q;
    logic [DATA_WIDTH-1:0] gap_q;
    logic [TW-1:0]         timer_q;
    logic [PW-1:0]         wait_q;
    logic [RCW-1:0]        rd_cnt_q;
    logic                  rd_wait_q;
    logic [DATA_WIDTH-1:0] body_q [5];
    logic [ADDR_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0] writedata_q;
    logic                  read_q;
    logic                  write_q;
    logic                  chipselect_q;
    logic                  body_ready_q;
    logic                  res_valid_q;
    logic [BAW-1:0]        res_idx_q;
    logic [DATA_WIDTH-1:0] res_x_q;
    logic [DATA_WIDTH-1:0] res_y_q;
    logic                  frame_done_q;
    logic                  error_q;
    logic [BAW-1:0]        last_idx;
    logic                  timed_out;

    assign last_idx  = n_q - BAW'(1);
    assign timed_out = (timer_q == TW'(TimeoutCycles));

    // Bus strobes clear one cycle after a write and after the read hold; the
    // sequencer only advances when the bus is free, which yields the idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            step_q       <= '0;
            idx_q        <= '0;
            n_q          <= '0;
            gap_q        <= '0;
            timer_q      <= '0;
            wait_q       <= '0;
            rd_cnt_q     <= '0;
            rd_wait_q    <= 1'b0;
            for (int k = 0; k < 5; k++) body_q[k] <= '0;
            address_q    <= '0;
            writedata_q  <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            chipselect_q <= 1'b0;
            body_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_idx_q    <= '0;
            res_x_q      <= '0;
            res_y_q      <= '0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            rd_wait_q    <= 1'b0;
            if (state_q == S_POLL && !timed_out)
                timer_q <= timer_q + TW'(1);

            if (write_q) begin
                write_q      <= 1'b0;
                chipselect_q <= 1'b0;
            end else if (read_q) begin
                if (rd_cnt_q == RCW'(ReadLatency - 1)) begin
                    read_q       <= 1'b0;
                    chipselect_q <= 1'b0;
                    rd_cnt_q     <= '0;
                    rd_wait_q    <= 1'b1;
                end else begin
                    rd_cnt_q <= rd_cnt_q + RCW'(1);
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (n_bodies == '0) begin
                                error_q <= 1'b1;
                            end else begin
                                n_q     <= n_bodies;
                                gap_q   <= gap;
                                error_q <= 1'b0;
                                step_q  <= '0;
                                state_q <= S_CFG;
                            end
                        end
                    end
                    S_CFG: begin
                        write_q      <= 1'b1;
                        chipselect_q <= 1'b1;
                        step_q       <= step_q + 3'd1;
                        case (step_q)
                            3'd0: begin
                                address_q   <= {OP_NBODY, IDX0};
                                writedata_q <= DATA_WIDTH'(n_q);
                            end
                            3'd1: begin
                                address_q   <= {OP_GAP, IDX0};
                                writedata_q <= gap_q;
                            end
                            3'd2: begin
                                address_q   <= {OP_READ, IDX0};
                                writedata_q <= '0;
                            end
                            default: begin
                                address_q   <= {OP_GO, IDX0};
                                writedata_q <= '0;
                                state_q     <= S_LOAD;
                                step_q      <= '0;
                                idx_q       <= '0;
                            end
                        endcase
                    end
                    S_LOAD: begin
                        if (step_q == 3'd0) begin
                            if (!body_ready_q) begin
                                body_ready_q <= 1'b1;
                            end else if (body_valid) begin
                                body_ready_q <= 1'b0;
                                body_q[0]    <= body_x;
                                body_q[1]    <= body_y;
                                body_q[2]    <= body_m;
                                body_q[3]    <= body_vx;
                                body_q[4]    <= body_vy;
                                step_q       <= 3'd1;
                            end
                        end else begin
                            // X..VY opcodes are contiguous, so step 1..5 maps onto them directly.
                            write_q      <= 1'b1;
                            chipselect_q <= 1'b1;
                            address_q    <= {OP_X + OPW'(step_q - 3'd1), idx_q};
                            writedata_q  <= body_q[step_q - 3'd1];
                            if (step_q == 3'd5) begin
                                step_q <= '0;
                                if (idx_q == last_idx) state_q <= S_ARM;
                                else                   idx_q   <= idx_q + BAW'(1);
                            end else begin
                                step_q <= step_q + 3'd1;
                            end
                        end
                    end
                    S_ARM: begin
                        write_q      <= 1'b1;
                        chipselect_q <= 1'b1;
                        address_q    <= {OP_GO, IDX0};
                        writedata_q  <= DATA_WIDTH'(1);
                        state_q      <= S_POLL;
                        step_q       <= '0;
                        timer_q      <= '0;
                    end
                    S_POLL: begin
                        if (step_q == 3'd1) begin
                            if (rd_wait_q) begin
                                if (readdata[0]) begin
                                    write_q      <= 1'b1;
                                    chipselect_q <= 1'b1;
                                    address_q    <= {OP_READ, IDX0};
                                    writedata_q  <= DATA_WIDTH'(1);
                                    state_q      <= S_RDBK;
                                    step_q       <= '0;
                                    idx_q        <= '0;
                                end else begin
                                    step_q <= 3'd2;
                                    wait_q <= '0;
                                end
                            end
                        end else if (timed_out) begin
                            write_q      <= 1'b1;
                            chipselect_q <= 1'b1;
                            address_q    <= {OP_GO, IDX0};
                            writedata_q  <= '0;
                            error_q      <= 1'b1;
                            state_q      <= S_IDLE;
                            step_q       <= '0;
                        end else if (step_q == 3'd0) begin
                            read_q       <= 1'b1;
                            chipselect_q <= 1'b1;
                            address_q    <= {OP_DONE, IDX0};
                            rd_cnt_q     <= '0;
                            step_q       <= 3'd1;
                        end else if (wait_q == PW'(PollInterval - 1)) begin
                            step_q <= '0;
                        end else begin
                            wait_q <= wait_q + PW'(1);
                        end
                    end
                    S_RDBK: begin
                        case (step_q)
                            3'd0: begin
                                read_q       <= 1'b1;
                                chipselect_q <= 1'b1;
                                address_q    <= {OP_RX, idx_q};
                                rd_cnt_q     <= '0;
                                step_q       <= 3'd1;
                            end
                            3'd1: begin
                                if (rd_wait_q) begin
                                    res_x_q      <= readdata;
                                    read_q       <= 1'b1;
                                    chipselect_q <= 1'b1;
                                    address_q    <= {OP_RY, idx_q};
                                    rd_cnt_q     <= '0;
                                    step_q       <= 3'd2;
                                end
                            end
                            3'd2: begin
                                if (rd_wait_q) begin
                                    res_y_q     <= readdata;
                                    res_idx_q   <= idx_q;
                                    res_valid_q <= 1'b1;
                                    step_q      <= 3'd3;
                                end
                            end
                            default: begin
                                // No further reads are issued until the held result is taken.
                                if (res_ready) begin
                                    res_valid_q <= 1'b0;
                                    step_q      <= '0;
                                    if (idx_q == last_idx) begin
                                        frame_done_q <= 1'b1;
                                        state_q      <= S_END;
                                    end else begin
                                        idx_q <= idx_q + BAW'(1);
                                    end
                                end
                            end
                        endcase
                    end
                    S_END: begin
                        write_q      <= 1'b1;
                        chipselect_q <= 1'b1;
                        writedata_q  <= '0;
                        if (step_q == 3'd0) begin
                            if (continuous && !stop) begin
                                address_q <= {OP_READ, IDX0};
                                state_q   <= S_POLL;
                                timer_q   <= '0;
                            end else begin
                                address_q <= {OP_GO, IDX0};
                                step_q    <= 3'd1;
                            end
                        end else begin
                            address_q <= {OP_READ, IDX0};
                            state_q   <= S_IDLE;
                            step_q    <= '0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        step_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign body_ready = body_ready_q;
    assign res_valid  = res_valid_q;
    assign res_idx    = res_idx_q;
    assign res_x      = res_x_q;
    assign res_y      = res_y_q;
    assign frame_done = frame_done_q;
    assign error      = error_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign read       = read_q;
    assign write      = write_q;
    assign chipselect = chipselect_q;

endmodule

// File: tb/tb_nbody_host_seq.sv
// Directed bench for nbody_host_seq with a small accelerator bus responder.
module tb_nbody_host_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  n_bodies = '0;
    logic [63:0] gap = '0;
    logic        continuous = 1'b0;
    logic        stop = 1'b0;
    logic        body_valid = 1'b0;
    logic        body_ready;
    logic [63:0] body_x = '0, body_y = '0, body_m = '0, body_vx = '0, body_vy = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [8:0]  res_idx;
    logic [63:0] res_x, res_y;
    logic        busy, frame_done, error;
    logic [15:0] address;
    logic [63:0] writedata;
    logic        read, write, chipselect;
    logic [63:0] readdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nbody_host_seq #(.TimeoutCycles(100)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_bodies(n_bodies), .gap(gap),
        .continuous(continuous), .stop(stop),
        .body_valid(body_valid), .body_ready(body_ready),
        .body_x(body_x), .body_y(body_y), .body_m(body_m), .body_vx(body_vx), .body_vy(body_vy),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_x(res_x), .res_y(res_y),
        .busy(busy), .frame_done(frame_done), .error(error),
        .address(address), .writedata(writedata), .read(read), .write(write),
        .chipselect(chipselect), .readdata(readdata)
    );

    // Accelerator responder: logs every bus write and read, answers DONE/READ_X/READ_Y.
    logic [15:0] wr_addr_log [$];
    logic [63:0] wr_data_log [$];
    logic [15:0] rd_addr_log [$];
    int          polls = 0, fd_cnt = 0, viol = 0;
    int          polls_base = 0, done_at = 0;
    logic        read_prev = 1'b0, write_prev = 1'b0;
    logic [15:0] addr_prev = '0;

    always @(posedge clk) begin
        read_prev  <= read;
        write_prev <= write;
        addr_prev  <= address;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if ((read && write) || ((read || write) && write_prev) || (write && read_prev) ||
            (read && read_prev && address != addr_prev))
            viol <= viol + 1;
        if (write && chipselect) begin
            wr_addr_log.push_back(address);
            wr_data_log.push_back(writedata);
        end
        if (read && chipselect && !read_prev) begin
            rd_addr_log.push_back(address);
            case (address[15:9])
                7'h40: begin
                    polls    <= polls + 1;
                    readdata <= (done_at != 0 && (polls + 1 - polls_base) >= done_at) ? 64'd1 : 64'd0;
                end
                7'h41:   readdata <= 64'h1000 + 64'(address[8:0]);
                7'h42:   readdata <= 64'h2000 + 64'(address[8:0]);
                default: readdata <= '0;
            endcase
        end
    end

    int wr_base, rd_base, fd_base;

    task automatic mark_bases();
        wr_base = wr_addr_log.size();
        rd_base = rd_addr_log.size();
        fd_base = fd_cnt;
        polls_base = polls;
    endtask

    task automatic pulse_start(input logic [8:0] n, input logic [63:0] g);
        @(negedge clk);
        start = 1'b1; n_bodies = n; gap = g;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed_body(input logic [63:0] x, y, m, vx, vy, output bit ok);
        int k;
        k = 0;
        body_valid = 1'b1; body_x = x; body_y = y; body_m = m; body_vx = vx; body_vy = vy;
        while (!body_ready && k < 200) begin @(negedge clk); k++; end
        ok = body_ready;
        @(negedge clk);
        body_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int k;
        k = 0;
        while (busy && k < limit) begin @(negedge clk); k++; end
        ok = !busy;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_res(input int limit, output bit ok);
        int k;
        k = 0;
        while (!res_valid && k < limit) begin @(negedge clk); k++; end
        ok = res_valid;
    endtask

    task automatic test_reset();
        logic [207:0] outs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        outs = {address, writedata, writedata, read, write, chipselect, busy, res_valid,
                body_ready, frame_done, error, res_idx, res_x[62:0]};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", outs);
        end
        checks++;
        if (res_y !== '0) begin
            errors++; $display("FAIL reset_res_y got %h want 0", res_y);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset: outputs checked");
    endtask

    task automatic test_reset_midwrite();
        int k;
        k = 0;
        pulse_start(9'd3, 64'd0);
        while (!write && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (write !== 1'b1) begin
            errors++; $display("FAIL midwrite_reach got write=%b want 1", write);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({address, writedata, read, write, chipselect, busy, res_valid} !== '0) begin
            errors++; $display("FAIL midwrite_reset got addr=%h wd=%h r=%b w=%b cs=%b busy=%b rv=%b want all 0",
                               address, writedata, read, write, chipselect, busy, res_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("reset mid-write: strobes checked");
    endtask

    task automatic test_load();
        logic [15:0] ea [20];
        logic [63:0] ed [20];
        bit ok;
        int k;
        ea = '{16'h0400, 16'h1000, 16'h0200, 16'h0000,
               16'h0600, 16'h0800, 16'h0A00, 16'h0C00, 16'h0E00,
               16'h0601, 16'h0801, 16'h0A01, 16'h0C01, 16'h0E01,
               16'h0602, 16'h0802, 16'h0A02, 16'h0C02, 16'h0E02, 16'h0000};
        ed = '{3, 0, 0, 0, 0, 0, 10, 20, 30, 1, 2, 11, 21, 31, 2, 4, 12, 22, 32, 1};
        mark_bases();
        done_at = 4; res_ready = 1'b0; continuous = 1'b0; stop = 1'b0;
        pulse_start(9'd3, 64'd0);
        for (int i = 0; i < 3; i++) begin
            feed_body(64'(i), 64'(2 * i), 64'(10 + i), 64'(20 + i), 64'(30 + i), ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL load_ready body=%0d got ready=0 want 1", i);
            end
        end
        k = 0;
        while (wr_addr_log.size() < wr_base + 20 && k < 500) begin @(negedge clk); k++; end
        checks++;
        if (wr_addr_log.size() < wr_base + 20) begin
            errors++; $display("FAIL load_write_count got %0d want 20", wr_addr_log.size() - wr_base);
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (wr_addr_log[wr_base + i] !== ea[i] || wr_data_log[wr_base + i] !== ed[i]) begin
                    errors++; $display("FAIL load_write[%0d] got %h=%0h want %h=%0h", i,
                                       wr_addr_log[wr_base + i], wr_data_log[wr_base + i], ea[i], ed[i]);
                end
            end
        end
        $display("load n=3: %0d writes observed", wr_addr_log.size() - wr_base);
    endtask

    task automatic test_poll_backpressure();
        bit ok;
        int rd_now;
        wait_res(500, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_res_valid got 0 want 1");
        end
        rd_now = rd_addr_log.size();
        checks++;
        if (rd_now - rd_base !== 6) begin
            errors++; $display("FAIL bp_reads_before got %0d want 6", rd_now - rd_base);
        end
        checks++;
        if (wr_addr_log.size() < wr_base + 21 || wr_addr_log[wr_base + 20] !== 16'h0200 ||
            wr_data_log[wr_base + 20] !== 64'd1) begin
            errors++; $display("FAIL read1_write got size=%0d want 0200=1 at slot 20",
                               wr_addr_log.size() - wr_base);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_idx !== 9'd0 || res_x !== 64'h1000 || res_y !== 64'h2000) begin
                errors++; $display("FAIL bp_hold cyc=%0d got v=%b i=%0d x=%h y=%h want 1 0 1000 2000",
                                   c, res_valid, res_idx, res_x, res_y);
            end
            checks++;
            if (read !== 1'b0 || rd_addr_log.size() !== rd_now) begin
                errors++; $display("FAIL bp_no_read cyc=%0d got read=%b reads=%0d want 0 %0d",
                                   c, read, rd_addr_log.size(), rd_now);
            end
        end
        $display("backpressure: result held 10 cycles");
    endtask

    task automatic test_readback();
        logic [15:0] er [10];
        bit ok;
        er = '{16'h8000, 16'h8000, 16'h8000, 16'h8000,
               16'h8200, 16'h8400, 16'h8201, 16'h8401, 16'h8202, 16'h8402};
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_res(200, ok);
            checks++;
            if (!ok || res_idx !== 9'(i) || res_x !== 64'h1000 + 64'(i) || res_y !== 64'h2000 + 64'(i)) begin
                errors++; $display("FAIL rdbk_result[%0d] got v=%b i=%0d x=%h y=%h want 1 %0d %h %h", i,
                                   res_valid, res_idx, res_x, res_y, i, 64'h1000 + 64'(i), 64'h2000 + 64'(i));
            end
            @(negedge clk);
        end
        wait_idle(200, ok);
        res_ready = 1'b0;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rdbk_idle got busy=1 want 0");
        end
        checks++;
        if (fd_cnt - fd_base !== 1) begin
            errors++; $display("FAIL rdbk_frame_done got %0d want 1", fd_cnt - fd_base);
        end
        checks++;
        if (rd_addr_log.size() - rd_base !== 10) begin
            errors++; $display("FAIL rdbk_read_count got %0d want 10", rd_addr_log.size() - rd_base);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (rd_addr_log[rd_base + i] !== er[i]) begin
                    errors++; $display("FAIL rdbk_read[%0d] got %h want %h", i, rd_addr_log[rd_base + i], er[i]);
                end
            end
        end
        checks++;
        if (wr_addr_log.size() - wr_base !== 23 ||
            wr_addr_log[wr_base + 21] !== 16'h0000 || wr_data_log[wr_base + 21] !== 64'd0 ||
            wr_addr_log[wr_base + 22] !== 16'h0200 || wr_data_log[wr_base + 22] !== 64'd0) begin
            errors++; $display("FAIL rdbk_end_writes got count=%0d want 23 ending 0000=0 0200=0",
                               wr_addr_log.size() - wr_base);
        end
        $display("readback n=3: %0d reads, %0d frame_done", rd_addr_log.size() - rd_base, fd_cnt - fd_base);
    endtask

    task automatic test_start_zero();
        mark_bases();
        pulse_start(9'd0, 64'd5);
        repeat (20) @(negedge clk);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_start got error=%b busy=%b want 1 0", error, busy);
        end
        checks++;
        if (wr_addr_log.size() !== wr_base || rd_addr_log.size() !== rd_base) begin
            errors++; $display("FAIL zero_bus got writes=%0d reads=%0d want 0 0",
                               wr_addr_log.size() - wr_base, rd_addr_log.size() - rd_base);
        end
        $display("start n_bodies=0: error=%b", error);
    endtask

    task automatic test_back_to_back_continuous();
        logic [15:0] ea [15];
        logic [63:0] ed [15];
        logic [15:0] er [6];
        bit ok;
        ea = '{16'h0400, 16'h1000, 16'h0200, 16'h0000,
               16'h0600, 16'h0800, 16'h0A00, 16'h0C00, 16'h0E00,
               16'h0000, 16'h0200, 16'h0200, 16'h0200, 16'h0000, 16'h0200};
        ed = '{1, 5, 0, 0, 7, 8, 9, 10, 11, 1, 1, 0, 1, 0, 0};
        er = '{16'h8000, 16'h8200, 16'h8400, 16'h8000, 16'h8200, 16'h8400};
        mark_bases();
        done_at = 1; continuous = 1'b1; stop = 1'b0; res_ready = 1'b1;
        pulse_start(9'd1, 64'd5);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL cont_accept got error=%b busy=%b want 0 1", error, busy);
        end
        feed_body(64'd7, 64'd8, 64'd9, 64'd10, 64'd11, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL cont_load_ready got 0 want 1");
        end
        pulse_start(9'd5, 64'd0);
        for (int f = 0; f < 2; f++) begin
            wait_res(300, ok);
            if (f == 1) stop = 1'b1;
            checks++;
            if (!ok || res_idx !== 9'd0 || res_x !== 64'h1000 || res_y !== 64'h2000) begin
                errors++; $display("FAIL cont_result[%0d] got v=%b i=%0d x=%h y=%h want 1 0 1000 2000",
                                   f, res_valid, res_idx, res_x, res_y);
            end
            @(negedge clk);
        end
        wait_idle(300, ok);
        stop = 1'b0; continuous = 1'b0; res_ready = 1'b0;
        checks++;
        if (!ok || fd_cnt - fd_base !== 2) begin
            errors++; $display("FAIL cont_frames got idle=%b frame_done=%0d want 1 2", ok, fd_cnt - fd_base);
        end
        checks++;
        if (wr_addr_log.size() - wr_base !== 15) begin
            errors++; $display("FAIL cont_write_count got %0d want 15", wr_addr_log.size() - wr_base);
        end else begin
            for (int i = 0; i < 15; i++) begin
                checks++;
                if (wr_addr_log[wr_base + i] !== ea[i] || wr_data_log[wr_base + i] !== ed[i]) begin
                    errors++; $display("FAIL cont_write[%0d] got %h=%0h want %h=%0h", i,
                                       wr_addr_log[wr_base + i], wr_data_log[wr_base + i], ea[i], ed[i]);
                end
            end
        end
        checks++;
        if (rd_addr_log.size() - rd_base !== 6) begin
            errors++; $display("FAIL cont_read_count got %0d want 6", rd_addr_log.size() - rd_base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (rd_addr_log[rd_base + i] !== er[i]) begin
                    errors++; $display("FAIL cont_read[%0d] got %h want %h", i, rd_addr_log[rd_base + i], er[i]);
                end
            end
        end
        $display("continuous n=1: %0d frames, %0d writes", fd_cnt - fd_base, wr_addr_log.size() - wr_base);
    endtask

    task automatic test_timeout();
        bit ok;
        int bad;
        bad = 0;
        mark_bases();
        done_at = 0;
        pulse_start(9'd1, 64'd0);
        feed_body(64'd1, 64'd2, 64'd3, 64'd4, 64'd5, ok);
        wait_idle(400, ok);
        checks++;
        if (!ok || error !== 1'b1) begin
            errors++; $display("FAIL timeout_state got idle=%b error=%b want 1 1", ok, error);
        end
        checks++;
        if (wr_addr_log.size() - wr_base !== 11 || wr_addr_log[wr_addr_log.size() - 1] !== 16'h0000 ||
            wr_data_log[wr_data_log.size() - 1] !== 64'd0) begin
            errors++; $display("FAIL timeout_go0 got count=%0d want 11 ending 0000=0", wr_addr_log.size() - wr_base);
        end
        for (int i = rd_base; i < rd_addr_log.size(); i++)
            if (rd_addr_log[i] !== 16'h8000) bad++;
        checks++;
        if (rd_addr_log.size() == rd_base || bad != 0) begin
            errors++; $display("FAIL timeout_polls got polls=%0d non_done=%0d want >0 0",
                               rd_addr_log.size() - rd_base, bad);
        end
        $display("timeout: error=%b, %0d polls", error, rd_addr_log.size() - rd_base);
    endtask

    initial begin
        test_reset();
        test_reset_midwrite();
        test_load();
        test_poll_backpressure();
        test_readback();
        test_start_zero();
        test_back_to_back_continuous();
        test_timeout();
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL bus_protocol got violations=%0d want 0", viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
